// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: issue and result bundle for the EX-stage mul/div unit.
// Upstream drives the i_* side and the unit drives the o_* side.
interface ex_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             i_vld;
  logic [2:0]       i_funct3;
  logic [XLEN-1:0]  i_op1;
  logic [XLEN-1:0]  i_op2;
  logic [TAG_W-1:0] i_rd_waddr;
  logic             i_rd_wen;
  logic [XLEN-1:0]  i_pc;
  logic             i_flush;
  logic             i_data_busy;
  logic             o_busy;
  logic             o_vld;
  logic [XLEN-1:0]  o_res;
  logic [TAG_W-1:0] o_rd_waddr;
  logic             o_rd_wen;
  logic [XLEN-1:0]  o_pc;

  modport master (
    output i_vld, i_funct3, i_op1, i_op2,
    output i_rd_waddr, i_rd_wen, i_pc,
    output i_flush, i_data_busy,
    input  o_busy, o_vld, o_res,
    input  o_rd_waddr, o_rd_wen, o_pc
  );

  modport slave (
    input  i_vld, i_funct3, i_op1, i_op2,
    input  i_rd_waddr, i_rd_wen, i_pc,
    input  i_flush, i_data_busy,
    output o_busy, o_vld, o_res,
    output o_rd_waddr, o_rd_wen, o_pc
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M/RV64M execute unit.
// Counted multiply, restoring divide, registered held result.
module ex_muldiv #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input logic        i_clk,
  input logic        i_rst,
  ex_muldiv_if.slave bus
);

  localparam int CW =
    $clog2(XLEN > MUL_LAT ? XLEN : MUL_LAT + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [TAG_W-1:0] wa_q, wa_d;
  logic             wen_q, wen_d;

  // Multiplier sees the bus on accept, latched operands in MUL.
  logic                     in_mul;
  logic [2:0]               mf3;
  logic [XLEN-1:0]          mop1, mop2;
  logic signed [XLEN:0]     ma, mb;
  logic signed [2*XLEN+1:0] prod;
  logic [1:0]               prod_unused;
  logic [XLEN-1:0]          mul_res;

  assign in_mul = (state_q == S_MUL);
  assign mf3    = in_mul ? f3_q : bus.i_funct3;
  assign mop1   = in_mul ? a_q : bus.i_op1;
  assign mop2   = in_mul ? b_q : bus.i_op2;
  assign ma = {((mf3 == 3'b001) || (mf3 == 3'b010))
               & mop1[XLEN-1], mop1};
  assign mb = {(mf3 == 3'b001) & mop2[XLEN-1], mop2};
  assign prod = (2*XLEN+2)'(ma) * (2*XLEN+2)'(mb);
  assign prod_unused = prod[2*XLEN+1:2*XLEN];
  assign mul_res = (mf3[1:0] == 2'b00) ?
                   prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // One restoring-division step on the magnitudes.
  logic [XLEN:0]   dsh, ddif;
  logic            dbit;
  logic [XLEN-1:0] quo_n, rem_n;

  assign dsh   = {rem_q, a_q[XLEN-1]};
  assign ddif  = dsh - {1'b0, b_q};
  assign dbit  = ~ddif[XLEN];
  assign rem_n = dbit ? ddif[XLEN-1:0] : dsh[XLEN-1:0];
  assign quo_n = {a_q[XLEN-2:0], dbit};

  // Issue decode: accept window, operand signs, fast paths.
  logic acc, sgn, n1, n2, dz, ovf;

  assign acc = bus.i_vld & ~bus.i_flush &
               ((state_q == S_IDLE) |
                ((state_q == S_DONE) & ~bus.i_data_busy));
  assign sgn = ~bus.i_funct3[0];
  assign n1  = sgn & bus.i_op1[XLEN-1];
  assign n2  = sgn & bus.i_op2[XLEN-1];
  assign dz  = (bus.i_op2 == '0);
  assign ovf = sgn & (bus.i_op1 == MIN_NEG) &
               (bus.i_op2 == '1);

  // Next state, datapath progress and accept latching.
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    res_d   = res_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    wa_d    = wa_q;
    wen_d   = wen_q;

    unique case (state_q)
      S_MUL: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          res_d   = mul_res;
        end
      end
      S_DIV: begin
        a_d   = quo_n;
        rem_d = rem_n;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (f3_q[1])
            res_d = negr_q ? -rem_n : rem_n;
          else
            res_d = negq_q ? -quo_n : quo_n;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (!bus.i_data_busy)
          state_d = S_IDLE;
      end
      default: begin
      end
    endcase

    if (acc) begin
      f3_d  = bus.i_funct3;
      wa_d  = bus.i_rd_waddr;
      wen_d = bus.i_rd_wen & (bus.i_rd_waddr != '0);
      pc_d  = bus.i_pc;
      if (!bus.i_funct3[2]) begin
        a_d   = bus.i_op1;
        b_d   = bus.i_op2;
        cnt_d = MUL_INIT;
        if (MUL_LAT == 1) begin
          state_d = S_DONE;
          res_d   = mul_res;
        end else begin
          state_d = S_MUL;
        end
      end else if (dz) begin
        res_d   = bus.i_funct3[1] ? bus.i_op1 : '1;
        state_d = S_DONE;
      end else if (ovf) begin
        res_d   = bus.i_funct3[1] ? '0 : bus.i_op1;
        state_d = S_DONE;
      end else begin
        a_d     = n1 ? -bus.i_op1 : bus.i_op1;
        b_d     = n2 ? -bus.i_op2 : bus.i_op2;
        rem_d   = '0;
        cnt_d   = '0;
        negq_d  = n1 ^ n2;
        negr_d  = n1;
        state_d = S_DIV;
      end
    end

    if (bus.i_flush)
      state_d = S_IDLE;
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      wa_q    <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      wa_q    <= wa_d;
      wen_q   <= wen_d;
    end
  end

  assign bus.o_vld      = (state_q == S_DONE);
  assign bus.o_busy     = (state_q == S_MUL) |
                          (state_q == S_DIV) |
                          ((state_q == S_DONE) &
                           bus.i_data_busy);
  assign bus.o_res      = res_q;
  assign bus.o_rd_waddr = wa_q;
  assign bus.o_rd_wen   = wen_q;
  assign bus.o_pc       = pc_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: vector table, random ops vs arithmetic model,
// and hand sequences for hold, flush, reset and XLEN=64.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32), .TAG_W(5)) b32 ();
  ex_muldiv_if #(.XLEN(64), .TAG_W(5)) b64 ();

  ex_muldiv #(.XLEN(32), .MUL_LAT(2), .TAG_W(5)) u32 (
    .i_clk(clk), .i_rst(rst), .bus(b32.slave)
  );
  ex_muldiv #(.XLEN(64), .MUL_LAT(2), .TAG_W(5)) u64 (
    .i_clk(clk), .i_rst(rst), .bus(b64.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model32(
    input logic [2:0] f3, input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int lat32(
    input logic [2:0] f3, input logic [31:0] a, b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  task automatic idle32();
    b32.i_vld = 0; b32.i_funct3 = 0;
    b32.i_op1 = 0; b32.i_op2 = 0;
    b32.i_rd_waddr = 0; b32.i_rd_wen = 0; b32.i_pc = 0;
    b32.i_flush = 0; b32.i_data_busy = 0;
  endtask

  task automatic drive32(input logic [2:0] f3,
                         input logic [31:0] a, b,
                         input logic [4:0] wa,
                         input logic we,
                         input logic [31:0] pc);
    b32.i_vld = 1; b32.i_funct3 = f3;
    b32.i_op1 = a; b32.i_op2 = b;
    b32.i_rd_waddr = wa; b32.i_rd_wen = we; b32.i_pc = pc;
  endtask

  // Present one op, count cycles to o_vld, check everything.
  task automatic run32(input string nm,
                       input logic [2:0] f3,
                       input logic [31:0] a, b,
                       input logic [4:0] wa,
                       input logic we,
                       input logic [31:0] pc,
                       input logic [31:0] er,
                       input int el);
    int n;
    @(negedge clk);
    drive32(f3, a, b, wa, we, pc);
    @(posedge clk); #1;
    b32.i_vld = 0;
    chk({nm, " busy"}, 64'(b32.o_busy), 64'(el > 1));
    n = 1;
    while (!b32.o_vld && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " lat"}, 64'(n), 64'(el));
    chk({nm, " res"}, 64'(b32.o_res), 64'(er));
    chk({nm, " idle"}, 64'(b32.o_busy), 64'(0));
    chk({nm, " wa"}, 64'(b32.o_rd_waddr), 64'(wa));
    chk({nm, " wen"}, 64'(b32.o_rd_wen),
        64'(we & (wa != 0)));
    chk({nm, " pc"}, 64'(b32.o_pc), 64'(pc));
    @(posedge clk); #1;
  endtask

  task automatic run64(input string nm,
                       input logic [2:0] f3,
                       input logic [63:0] a, b,
                       input logic [63:0] er,
                       input int el);
    int n;
    @(negedge clk);
    b64.i_vld = 1; b64.i_funct3 = f3;
    b64.i_op1 = a; b64.i_op2 = b;
    b64.i_rd_waddr = 5'd3; b64.i_rd_wen = 1;
    @(posedge clk); #1;
    b64.i_vld = 0;
    n = 1;
    while (!b64.o_vld && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " lat"}, 64'(n), 64'(el));
    chk({nm, " res"}, b64.o_res, er);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic [31:0] er;
    int          el;
  } vec_t;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[$];

  initial begin
    int n;
    logic seen;
    logic [2:0] f3;
    logic [31:0] a, b;

    vt.push_back('{"mul", 3'd0, 32'hFFFF_FFFD, 32'd7,
                   5'd1, 32'hFFFF_FFEB, 2});
    vt.push_back('{"mulh", 3'd1, 32'h8000_0000,
                   32'h8000_0000, 5'd2, 32'h4000_0000, 2});
    vt.push_back('{"mulhu", 3'd3, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 2});
    vt.push_back('{"mulhsu", 3'd2, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 2});
    vt.push_back('{"divu", 3'd5, 32'd100, 32'd7,
                   5'd5, 32'd14, 33});
    vt.push_back('{"remu", 3'd7, 32'd100, 32'd7,
                   5'd6, 32'd2, 33});
    vt.push_back('{"div", 3'd4, 32'hFFFF_FF9C, 32'd7,
                   5'd7, 32'hFFFF_FFF2, 33});
    vt.push_back('{"rem", 3'd6, 32'hFFFF_FF9C, 32'd7,
                   5'd8, 32'hFFFF_FFFE, 33});
    vt.push_back('{"div0", 3'd4, 32'd5, 32'd0,
                   5'd9, 32'hFFFF_FFFF, 1});
    vt.push_back('{"rem0", 3'd6, 32'd5, 32'd0,
                   5'd10, 32'd5, 1});
    vt.push_back('{"divovf", 3'd4, 32'h8000_0000,
                   32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1});
    vt.push_back('{"removf", 3'd6, 32'h8000_0000,
                   32'hFFFF_FFFF, 5'd12, 32'd0, 1});
    vt.push_back('{"divuovf", 3'd5, 32'h8000_0000,
                   32'hFFFF_FFFF, 5'd13, 32'd0, 33});

    idle32();
    b64.i_vld = 0; b64.i_funct3 = 0;
    b64.i_op1 = 0; b64.i_op2 = 0;
    b64.i_rd_waddr = 0; b64.i_rd_wen = 0; b64.i_pc = 0;
    b64.i_flush = 0; b64.i_data_busy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    chk("rst vld", 64'(b32.o_vld), 64'(0));
    chk("rst busy", 64'(b32.o_busy), 64'(0));
    chk("rst res", 64'(b32.o_res), 64'(0));
    chk("rst wa", 64'(b32.o_rd_waddr), 64'(0));
    chk("rst wen", 64'(b32.o_rd_wen), 64'(0));
    chk("rst pc", 64'(b32.o_pc), 64'(0));

    foreach (vt[i])
      run32(vt[i].nm, vt[i].f3, vt[i].a, vt[i].b,
            vt[i].wa, 1'b1, 32'h1000 + 32'(i) * 4,
            vt[i].er, vt[i].el);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run32("rand", f3, a, b, 5'($urandom),
            1'($urandom), $urandom,
            model32(f3, a, b), lat32(f3, a, b));
    end

    // Hold in DONE, then release with a new MUL.
    @(negedge clk);
    b32.i_data_busy = 1;
    drive32(3'd0, 32'd3, 32'd5, 5'd1, 1'b1, 32'h40);
    @(posedge clk); #1;
    b32.i_vld = 0;
    n = 1;
    while (!b32.o_vld && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("hold lat", 64'(n), 64'(2));
    for (int k = 0; k < 4; k++) begin
      chk("hold vld", 64'(b32.o_vld), 64'(1));
      chk("hold res", 64'(b32.o_res), 64'(15));
      chk("hold busy", 64'(b32.o_busy), 64'(1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    b32.i_data_busy = 0;
    drive32(3'd0, 32'd6, 32'd7, 5'd2, 1'b1, 32'h44);
    @(posedge clk); #1;
    b32.i_vld = 0;
    chk("b2b consumed", 64'(b32.o_vld), 64'(0));
    chk("b2b busy", 64'(b32.o_busy), 64'(1));
    n = 1;
    while (!b32.o_vld && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b lat", 64'(n), 64'(2));
    chk("b2b res", 64'(b32.o_res), 64'(42));
    @(posedge clk); #1;

    // Flush a held result.
    @(negedge clk);
    b32.i_data_busy = 1;
    drive32(3'd0, 32'd2, 32'd2, 5'd1, 1'b1, 32'h48);
    @(posedge clk); #1;
    b32.i_vld = 0;
    n = 1;
    while (!b32.o_vld && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("fdone lat", 64'(n), 64'(2));
    @(negedge clk);
    b32.i_flush = 1;
    @(posedge clk); #1;
    b32.i_flush = 0;
    chk("fdone vld", 64'(b32.o_vld), 64'(0));
    chk("fdone busy", 64'(b32.o_busy), 64'(0));
    b32.i_data_busy = 0;

    // Flush at cycle 10 of a DIV.
    @(negedge clk);
    drive32(3'd5, 32'd100, 32'd7, 5'd1, 1'b1, 32'h50);
    @(posedge clk); #1;
    b32.i_vld = 0;
    n = 1;
    while (n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("fdiv busy pre", 64'(b32.o_busy), 64'(1));
    @(negedge clk);
    b32.i_flush = 1;
    @(posedge clk); #1;
    b32.i_flush = 0;
    chk("fdiv busy", 64'(b32.o_busy), 64'(0));
    seen = 0;
    repeat (40) begin
      seen |= b32.o_vld;
      @(posedge clk); #1;
    end
    chk("fdiv no vld", 64'(seen), 64'(0));

    // Flush coincident with a valid op.
    @(negedge clk);
    drive32(3'd0, 32'd9, 32'd9, 5'd1, 1'b1, 32'h60);
    b32.i_flush = 1;
    @(posedge clk); #1;
    b32.i_vld = 0;
    b32.i_flush = 0;
    chk("fvld busy", 64'(b32.o_busy), 64'(0));
    seen = 0;
    repeat (4) begin
      seen |= b32.o_vld;
      @(posedge clk); #1;
    end
    chk("fvld no vld", 64'(seen), 64'(0));

    // Reset in the middle of a DIV.
    @(negedge clk);
    drive32(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd9, 1'b1,
            32'h1234);
    @(posedge clk); #1;
    b32.i_vld = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("mrst vld", 64'(b32.o_vld), 64'(0));
    chk("mrst busy", 64'(b32.o_busy), 64'(0));
    chk("mrst res", 64'(b32.o_res), 64'(0));
    chk("mrst wa", 64'(b32.o_rd_waddr), 64'(0));
    chk("mrst wen", 64'(b32.o_rd_wen), 64'(0));
    chk("mrst pc", 64'(b32.o_pc), 64'(0));
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    run32("post rst", 3'd5, 32'd100, 32'd7, 5'd1, 1'b1,
          32'h70, 32'd14, 33);

    run64("divu64", 3'd5, 64'd100, 64'd7, 64'd14, 65);
    run64("div64", 3'd4, -64'sd100, 64'd7, -64'sd14, 65);
    run64("mulhu64", 3'd3, '1, '1,
          64'hFFFF_FFFF_FFFF_FFFE, 2);
    run64("divovf64", 3'd4, 64'h8000_0000_0000_0000, '1,
          64'h8000_0000_0000_0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle execute unit for the RV32M/RV64M multiply/divide group.
- Sits beside the single-cycle ALU in the EX stage and produces an EX/MEM-style registered result.
- Stalls upstream while an operation is in flight and holds its result while the data side is busy.
- Adds width generality, configurable multiply latency, divide fast-paths and flush, none of which the single-cycle ALU has.

Parameters:
XLEN, 32, datapath width in bits (32 or 64)
MUL_LAT, 2, cycles from accept to result for MUL* ops (>=1)
TAG_W, 5, width of destination register address carried through

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_vld  in  1  valid M-extension op presented this cycle
i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_op1  in  XLEN  rs1 data
i_op2  in  XLEN  rs2 data
i_rd_waddr  in  TAG_W  destination register
i_rd_wen  in  1  destination write enable
i_pc  in  XLEN  instruction PC, carried through
i_flush  in  1  kill in-flight/accepting op
i_data_busy  in  1  downstream stall; hold result
o_busy  out  1  unit cannot accept; upstream must stall
o_vld  out  1  result valid
o_res  out  XLEN  result
o_rd_waddr  out  TAG_W  carried destination
o_rd_wen  out  1  carried write enable
o_pc  out  XLEN  carried PC

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset: state IDLE; o_vld=0, o_busy=0, o_res=0, o_rd_waddr=0, o_rd_wen=0, o_pc=0.
- Accept: i_vld & !i_flush & (state==IDLE | (state==DONE & !i_data_busy)). Operands, funct3, rd_waddr, rd_wen and pc are latched on the accept edge.
- o_busy is asserted in MUL and DIV, and in DONE while i_data_busy=1. o_busy is a pure function of state and i_data_busy.
- MUL ops:
  - Product is computed at 2*XLEN bits; operands are sign/zero-extended per op (MULHSU: op1 signed, op2 unsigned).
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - A down-counter loaded with MUL_LAT-1 runs in MUL; enter DONE when it reaches 0.
  - o_vld rises exactly MUL_LAT cycles after the accept edge.
- DIV ops:
  - Restoring divider on magnitudes, one quotient bit per cycle; bit counter wraps from XLEN-1 to 0.
  - Enter DONE after XLEN iterations, so o_vld rises XLEN+1 cycles after accept.
  - Signs fix-up: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Fast-path, 1-cycle latency, straight to DONE:
    - divisor=0: quotient = all ones, remainder = dividend.
    - signed overflow (op1 = most-negative, op2 = -1): quotient = op1, remainder = 0.
- DONE:
  - o_vld=1 and outputs are stable while i_data_busy=1.
  - On a cycle with i_data_busy=0 the result is consumed. Next state is MUL/DIV/DONE if a new op is accepted in the same cycle, else IDLE with o_vld=0.
- Flush:
  - i_flush=1 forces IDLE next cycle from any state, and o_vld=0 next cycle.
  - i_flush beats a simultaneous i_vld; that op is not accepted.
  - Flush in DONE while i_data_busy=1 discards the held result.
- Reset mid-operation aborts it; the reset values above apply on the next edge.
- o_rd_wen is forced 0 when i_rd_waddr==0 at accept.

Test Plan:
- XLEN=32, MUL_LAT=2: MUL op1=0xFFFFFFFD, op2=7 -> o_vld exactly 2 cycles after accept, o_res=0xFFFFFFEB; o_busy high 1 cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 100/7 -> o_vld 33 cycles after accept, o_res=14; REMU same operands -> 2; DIV -100/7 -> 0xFFFFFFF2 (-14); REM -100/7 -> 0xFFFFFFFE (-2).
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at 1-cycle latency; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Hold and back-to-back: assert i_data_busy for 4 cycles in DONE -> o_res/o_vld stable and o_busy=1. Release with a new MUL presented -> accepted that cycle, old result consumed, new o_vld after MUL_LAT.
- Flush: flush at cycle 10 of a DIV -> IDLE next cycle, no o_vld ever for that op. Flush coincident with i_vld -> not accepted. Assert i_rst mid-DIV -> all outputs 0 next cycle. Repeat DIVU 100/7 at XLEN=64 -> 14 after 65 cycles.
